// File: rtl/upsample2x.sv
// 2x spatial upsampler: streams a CHANNELS x IN_SIZE x IN_SIZE map from a source BRAM
// and writes each sample as a 2x2 block into a destination BRAM (replicate or zero-fill).
module upsample2x #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_SIZE    = 14,
    parameter int ZERO_FILL  = 0,
    localparam int OUT_SIZE  = 2 * IN_SIZE,
    localparam int SA_W      = $clog2(CHANNELS * IN_SIZE * IN_SIZE),
    localparam int DA_W      = $clog2(CHANNELS * OUT_SIZE * OUT_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [SA_W-1:0]              src_addr,
    output logic                         src_en,
    input  logic signed [DATA_WIDTH-1:0] src_q,
    output logic [DA_W-1:0]              dst_addr,
    output logic                         dst_en,
    output logic                         dst_we,
    output logic signed [DATA_WIDTH-1:0] dst_d,
    output logic                         busy,
    output logic                         done
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] CAP    = 3'd2;
    localparam logic [2:0] W0     = 3'd3;
    localparam logic [2:0] W1     = 3'd4;
    localparam logic [2:0] W2     = 3'd5;
    localparam logic [2:0] W3     = 3'd6;
    localparam logic [2:0] FINISH = 3'd7;

    localparam logic [15:0] CH_LAST = 16'(CHANNELS - 1);
    localparam logic [15:0] RC_LAST = 16'(IN_SIZE - 1);

    logic [2:0]                   state;
    logic [15:0]                  ch, r, q;
    logic signed [DATA_WIDTH-1:0] hold;
    logic                         rd_pend;
    logic [31:0]                  base;
    logic                         last;
    logic signed [DATA_WIDTH-1:0] fill;

    // Destination index of the top-left corner of the current 2x2 block.
    always_comb begin
        base = (32'(ch) * 32'(OUT_SIZE) + 32'(r) * 32'd2) * 32'(OUT_SIZE) + 32'(q) * 32'd2;
        last = (ch == CH_LAST) && (r == RC_LAST) && (q == RC_LAST);
        fill = (ZERO_FILL != 0) ? '0 : hold;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ch       <= '0;
            r        <= '0;
            q        <= '0;
            hold     <= '0;
            rd_pend  <= 1'b0;
            src_addr <= '0;
            src_en   <= 1'b0;
            dst_addr <= '0;
            dst_en   <= 1'b0;
            dst_we   <= 1'b0;
            dst_d    <= '0;
            done     <= 1'b0;
        end else begin
            src_en  <= 1'b0;
            dst_en  <= 1'b0;
            dst_we  <= 1'b0;
            done    <= 1'b0;
            // Read data lands one cycle after each read; the prefetch issued in W3
            // therefore arrives during W0 and is forwarded straight to dst_d there.
            rd_pend <= src_en;
            if (rd_pend)
                hold <= src_q;
            case (state)
                IDLE: if (start) begin
                    ch       <= '0;
                    r        <= '0;
                    q        <= '0;
                    src_addr <= '0;
                    src_en   <= 1'b1;
                    state    <= RD;
                end
                RD:  state <= CAP;
                CAP: state <= W0;
                W0: begin
                    dst_en   <= 1'b1;
                    dst_we   <= 1'b1;
                    dst_addr <= DA_W'(base);
                    dst_d    <= rd_pend ? src_q : hold;
                    state    <= W1;
                end
                W1: begin
                    dst_en   <= 1'b1;
                    dst_we   <= 1'b1;
                    dst_addr <= DA_W'(base + 32'd1);
                    dst_d    <= fill;
                    state    <= W2;
                end
                W2: begin
                    dst_en   <= 1'b1;
                    dst_we   <= 1'b1;
                    dst_addr <= DA_W'(base + 32'(OUT_SIZE));
                    dst_d    <= fill;
                    state    <= W3;
                end
                W3: begin
                    dst_en   <= 1'b1;
                    dst_we   <= 1'b1;
                    dst_addr <= DA_W'(base + 32'(OUT_SIZE) + 32'd1);
                    dst_d    <= fill;
                    if (last) begin
                        state <= FINISH;
                    end else begin
                        if (q == RC_LAST) begin
                            q <= '0;
                            if (r == RC_LAST) begin
                                r  <= '0;
                                ch <= ch + 16'd1;
                            end else begin
                                r <= r + 16'd1;
                            end
                        end else begin
                            q <= q + 16'd1;
                        end
                        src_addr <= src_addr + SA_W'(1);
                        src_en   <= 1'b1;
                        state    <= CAP;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
